// File: rtl/ctrl_pkg.sv
// Shared encodings for the datapath control sequencer: FSM states, instruction
// field constants, branch condition codes and flag bit positions.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_HALT
  } state_t;

  localparam logic [3:0] OP_BCOND = 4'hC;
  localparam logic [3:0] OP_HALT  = 4'hF;
  localparam logic [3:0] EXT_CMP  = 4'hB;

  localparam logic [3:0] CC_EQ = 4'h0;
  localparam logic [3:0] CC_NE = 4'h1;
  localparam logic [3:0] CC_CS = 4'h2;
  localparam logic [3:0] CC_CC = 4'h3;
  localparam logic [3:0] CC_FS = 4'h4;
  localparam logic [3:0] CC_FC = 4'h5;
  localparam logic [3:0] CC_LO = 4'h6;
  localparam logic [3:0] CC_HS = 4'h7;
  localparam logic [3:0] CC_UC = 4'hE;

  localparam int FLAG_C = 0;
  localparam int FLAG_L = 1;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 4;

  // Undefined condition codes fall through to "never taken".
  function automatic logic cond_true(input logic [3:0] cond, input logic [4:0] flags);
    logic taken;
    taken = 1'b0;
    case (cond)
      CC_EQ:   taken = flags[FLAG_Z];
      CC_NE:   taken = !flags[FLAG_Z];
      CC_CS:   taken = flags[FLAG_C];
      CC_CC:   taken = !flags[FLAG_C];
      CC_FS:   taken = flags[FLAG_F];
      CC_FC:   taken = !flags[FLAG_F];
      CC_LO:   taken = flags[FLAG_L];
      CC_HS:   taken = !flags[FLAG_L];
      CC_UC:   taken = 1'b1;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/reg_dec.sv
// 4-to-16 one-hot decoder with enable; drives the register write strobe.
module reg_dec (
  input  logic        en,
  input  logic [3:0]  sel,
  output logic [15:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/datapath_ctrl.sv
// Multi-cycle fetch/decode/execute sequencer for the register-file/ALU datapath:
// fetches over req/ack, presents Opcode, strobes RegEnable, tracks flags and branches.
module datapath_ctrl
  import ctrl_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  output logic [ADDR_W-1:0] InstrAddr,
  output logic              InstrReq,
  input  logic              InstrAck,
  input  logic [15:0]       InstrData,
  input  logic [4:0]        Flags,
  output logic [15:0]       Opcode,
  output logic [15:0]       RegEnable,
  output logic              Cin,
  output logic              Busy,
  output logic              Halted
);

  localparam int EXT_W = (ADDR_W > 8) ? ADDR_W : 8;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic [15:0]       ir, ir_nxt;
  logic [4:0]        flag_reg, flag_nxt;
  logic [15:0]       opcode_q, opcode_nxt;

  logic [3:0]              major;
  logic                    is_cmp;
  logic signed [EXT_W-1:0] disp_ext;
  logic [ADDR_W-1:0]       disp;

  assign major    = ir[15:12];
  assign is_cmp   = (major == 4'h0) && (ir[7:4] == EXT_CMP);
  // Sign-extend the 8-bit displacement, then keep ADDR_W bits so PC math wraps.
  assign disp_ext = EXT_W'(signed'(ir[7:0]));
  assign disp     = disp_ext[ADDR_W-1:0];

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= ST_IDLE;
      pc       <= '0;
      ir       <= '0;
      flag_reg <= '0;
      opcode_q <= '0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      ir       <= ir_nxt;
      flag_reg <= flag_nxt;
      opcode_q <= opcode_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    ir_nxt     = ir;
    flag_nxt   = flag_reg;
    opcode_nxt = opcode_q;
    case (state)
      ST_IDLE, ST_HALT: begin
        if (Start) begin
          pc_nxt    = '0;
          state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (InstrAck) begin
          ir_nxt    = InstrData;
          state_nxt = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (major == OP_HALT) begin
          state_nxt = ST_HALT;
        end else if (major == OP_BCOND) begin
          pc_nxt    = cond_true(ir[11:8], flag_reg) ? (pc + disp) : (pc + ADDR_W'(1));
          state_nxt = ST_FETCH;
        end else begin
          // Opcode launches a full cycle ahead of the EXEC write edge.
          opcode_nxt = ir;
          state_nxt  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        flag_nxt  = Flags;
        pc_nxt    = pc + ADDR_W'(1);
        state_nxt = ST_FETCH;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign InstrAddr = pc;
  assign InstrReq  = (state == ST_FETCH);
  assign Busy      = (state == ST_FETCH) || (state == ST_DECODE) || (state == ST_EXEC);
  assign Halted    = (state == ST_HALT);
  assign Opcode    = opcode_q;
  assign Cin       = flag_reg[FLAG_C];

  reg_dec u_reg_dec (
    .en    ((state == ST_EXEC) && !is_cmp),
    .sel   (ir[11:8]),
    .onehot(RegEnable)
  );

endmodule

// File: tb/tb_datapath_ctrl.sv
// Bench for datapath_ctrl: instruction-level reference model checked every cycle,
// plus directed programs with literal expectations at fixed cycle offsets.
module tb_datapath_ctrl;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [7:0]  InstrAddr;
  logic        InstrReq;
  logic        InstrAck;
  logic [15:0] InstrData;
  logic [4:0]  Flags = 5'b0;
  logic [15:0] Opcode;
  logic [15:0] RegEnable;
  logic        Cin, Busy, Halted;

  int tests = 0;
  int fails = 0;
  int n = 0;
  logic cmp_en = 1'b0;

  datapath_ctrl #(.ADDR_W(8)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start),
    .InstrAddr(InstrAddr), .InstrReq(InstrReq), .InstrAck(InstrAck),
    .InstrData(InstrData), .Flags(Flags), .Opcode(Opcode),
    .RegEnable(RegEnable), .Cin(Cin), .Busy(Busy), .Halted(Halted)
  );

  always #5 Clk = ~Clk;

  // Instruction memory responder: ack after ack_delay waiting cycles; optional stray acks.
  logic [15:0] mem [256];
  int   ack_delay = 0;
  int   wait_cnt = 0;
  logic stray_en = 1'b0;

  always_comb begin
    InstrData = mem[InstrAddr];
    InstrAck  = (stray_en && !InstrReq) || (InstrReq && (wait_cnt >= ack_delay));
  end

  always @(posedge Clk) wait_cnt <= (InstrReq && !InstrAck) ? wait_cnt + 1 : 0;

  // Reference model: mode 0 idle, 1 waiting on a fetch, 2 instruction in flight
  // (k = cycles since the ack), 3 halted.
  int          m_mode = 0;
  int          m_k = 0;
  logic [7:0]  m_pc = 8'h00;
  logic [15:0] m_ir = 16'h0000;
  logic [15:0] m_op = 16'h0000;
  logic [4:0]  m_fl = 5'b0;

  function automatic logic taken(input logic [3:0] c, input logic [4:0] f);
    logic t;
    case (c)
      4'd0:    t = f[3];
      4'd1:    t = !f[3];
      4'd2:    t = f[0];
      4'd3:    t = !f[0];
      4'd4:    t = f[2];
      4'd5:    t = !f[2];
      4'd6:    t = f[1];
      4'd7:    t = !f[1];
      4'd14:   t = 1'b1;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      m_mode <= 0; m_k <= 0; m_pc <= 8'h00; m_ir <= 16'h0; m_op <= 16'h0; m_fl <= 5'b0;
    end else begin
      case (m_mode)
        1: if (InstrAck) begin
          m_ir <= InstrData; m_mode <= 2; m_k <= 1;
        end
        2: begin
          if (m_k == 1) begin
            if (m_ir[15:12] == 4'hF) m_mode <= 3;
            else if (m_ir[15:12] == 4'hC) begin
              // 8-bit add of the raw byte is the signed displacement modulo 256
              m_pc   <= taken(m_ir[11:8], m_fl) ? m_pc + m_ir[7:0] : m_pc + 8'd1;
              m_mode <= 1;
            end else begin
              m_op <= m_ir; m_k <= 2;
            end
          end else begin
            m_fl <= Flags; m_pc <= m_pc + 8'd1; m_mode <= 1;
          end
        end
        default: if (Start) begin
          m_pc <= 8'h00; m_mode <= 1;
        end
      endcase
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  logic [15:0] exp_re;
  always @(negedge Clk) begin
    if (cmp_en) begin
      exp_re = 16'h0;
      if (m_mode == 2 && m_k == 2 && !(m_ir[15:12] == 4'h0 && m_ir[7:4] == 4'hB))
        exp_re = 16'd1 << m_ir[11:8];
      check1("m_req", InstrReq, m_mode == 1);
      check1("m_busy", Busy, (m_mode == 1) || (m_mode == 2));
      check1("m_halted", Halted, m_mode == 3);
      check("m_addr", {8'h00, InstrAddr}, {8'h00, m_pc});
      check("m_opcode", Opcode, m_op);
      check("m_regen", RegEnable, exp_re);
      check1("m_cin", Cin, m_fl[0]);
    end
  end

  task automatic pulse_start;
    @(posedge Clk); #1 Start = 1'b1;
    @(posedge Clk); #1 Start = 1'b0;
    n = -1;
  endtask

  task automatic go_n(input int k);
    while (n < k) begin
      @(negedge Clk);
      n++;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
    #1 Reset = 1'b0;
    repeat (2) @(negedge Clk);
    cmp_en = 1'b1;
    check1("rst_req", InstrReq, 1'b0);
    check("rst_regen", RegEnable, 16'h0000);
    check("rst_opcode", Opcode, 16'h0000);
    check1("rst_busy", Busy, 1'b0);
    check1("rst_halted", Halted, 1'b0);
    check1("rst_cin", Cin, 1'b0);
    @(posedge Clk); #1 Reset = 1'b1;

    // Reset in the middle of a stalled fetch
    mem[0] = 16'h0152; ack_delay = 3;
    pulse_start;
    go_n(0);
    check1("midfetch_req", InstrReq, 1'b1);
    #2 Reset = 1'b0;
    #1;
    check1("async_rst_req", InstrReq, 1'b0);
    check1("async_rst_busy", Busy, 1'b0);
    check("async_rst_regen", RegEnable, 16'h0000);
    @(posedge Clk); #1 Reset = 1'b1;

    // ALU op to R1 with carry out, then HALT
    mem[0] = 16'h0152; mem[1] = 16'hF000; ack_delay = 0; Flags = 5'b00001;
    pulse_start;
    go_n(0);
    check1("alu_req", InstrReq, 1'b1);
    check("alu_addr0", {8'h00, InstrAddr}, 16'h0000);
    go_n(2);
    check("alu_opcode", Opcode, 16'h0152);
    check("alu_regen", RegEnable, 16'h0002);
    go_n(3);
    check("alu_regen_off", RegEnable, 16'h0000);
    check("alu_next_addr", {8'h00, InstrAddr}, 16'h0001);
    check1("alu_cin", Cin, 1'b1);
    go_n(5);
    check1("halt_halted", Halted, 1'b1);
    check1("halt_busy", Busy, 1'b0);

    // CMP sets Z, then BEQ -2 from address 1 wraps to 0xFF
    mem[0] = 16'h02B3; mem[1] = 16'hC0FE; mem[255] = 16'hF000; Flags = 5'b01000;
    pulse_start;
    go_n(0);
    check("cmp_restart_addr", {8'h00, InstrAddr}, 16'h0000);
    go_n(2);
    check("cmp_regen", RegEnable, 16'h0000);
    check("cmp_opcode", Opcode, 16'h02B3);
    go_n(3);
    check1("cmp_cin", Cin, 1'b0);
    go_n(5);
    check("beq_wrap_addr", {8'h00, InstrAddr}, 16'h00FF);
    go_n(7);
    check1("beq_halted", Halted, 1'b1);

    // BNE with Z=1 not taken; BUC +2 taken
    mem[0] = 16'hC1FE; mem[1] = 16'hCE02; mem[3] = 16'hF000;
    pulse_start;
    go_n(2);
    check("bne_not_taken", {8'h00, InstrAddr}, 16'h0001);
    check("bne_opcode_hold", Opcode, 16'h02B3);
    go_n(4);
    check("buc_taken", {8'h00, InstrAddr}, 16'h0003);
    go_n(6);
    check1("buc_halted", Halted, 1'b1);

    // Slow fetch with stray acks outside FETCH and a Start while busy
    mem[0] = 16'h0A31; mem[1] = 16'hF000; Flags = 5'b00000;
    ack_delay = 5; stray_en = 1'b1;
    pulse_start;
    go_n(2);
    Start = 1'b1;
    go_n(3);
    Start = 1'b0;
    go_n(4);
    check1("stall_req", InstrReq, 1'b1);
    check("stall_addr", {8'h00, InstrAddr}, 16'h0000);
    go_n(7);
    check("slow_regen", RegEnable, 16'h0400);
    check("slow_opcode", Opcode, 16'h0A31);
    go_n(8);
    check("slow_next_addr", {8'h00, InstrAddr}, 16'h0001);
    check1("slow_req", InstrReq, 1'b1);
    check1("slow_cin", Cin, 1'b0);
    go_n(15);
    check1("slow_halted", Halted, 1'b1);

    stray_en = 1'b0;
    go_n(17);
    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
